// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
// uart_rx_deserializer
// UART receive path: start bit (0), 8 data bits LSB first, optional parity
// bit, one stop bit (1). The line is resynchronised and then sampled at the
// middle of each bit using a clock-per-bit counter.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           asynchronous, active-high reset
//   rx_in         serial line (asynchronous to clk, idles high)
//   p_data        last received byte, bit 0 = first data bit on the line
//   data_valid    one-cycle pulse when p_data is updated
//   parity_error  one-cycle pulse with data_valid when parity mismatches
//   framing_error one-cycle pulse when the stop bit is sampled low
//   busy          high whenever the receiver is not idle
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT      = 5208,
    parameter int CLK_COUNTER_WIDTH = $clog2(CLKS_PER_BIT),
    parameter bit PARITY_EN         = 1'b0,
    parameter bit PARITY_ODD        = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] p_data,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CLK_COUNTER_WIDTH-1:0] CNT_HALF_LAST = CLK_COUNTER_WIDTH'(HALF - 1);
    localparam logic [CLK_COUNTER_WIDTH-1:0] CNT_BIT_LAST  = CLK_COUNTER_WIDTH'(CLKS_PER_BIT - 1);

    state_t                       state, state_next;
    logic [CLK_COUNTER_WIDTH-1:0] clk_cnt, cnt_next;
    logic [2:0]                   bit_idx, idx_next;
    logic [7:0]                   shift_reg, shift_next;
    logic                         parity_bit, par_next;
    logic [7:0]                   pd_next;
    logic                         dv_next, pe_next, fe_next;

    // Two-flop synchroniser; both stages reset to the idle (high) level.
    logic rx_meta, rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            p_data        <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_next;
            clk_cnt       <= cnt_next;
            bit_idx       <= idx_next;
            shift_reg     <= shift_next;
            parity_bit    <= par_next;
            p_data        <= pd_next;
            data_valid    <= dv_next;
            parity_error  <= pe_next;
            framing_error <= fe_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = clk_cnt;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        par_next   = parity_bit;
        pd_next    = p_data;
        dv_next    = 1'b0;
        pe_next    = 1'b0;
        fe_next    = 1'b0;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    cnt_next   = '0;
                end
            end

            // Re-check the line at mid start bit to reject short glitches.
            S_START: begin
                if (clk_cnt == CNT_HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next = S_DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = clk_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (clk_cnt == CNT_BIT_LAST) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_next = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = clk_cnt + 1'b1;
                end
            end

            S_PARITY: begin
                if (clk_cnt == CNT_BIT_LAST) begin
                    cnt_next   = '0;
                    par_next   = rx_s;
                    state_next = S_STOP;
                end else begin
                    cnt_next = clk_cnt + 1'b1;
                end
            end

            // Returning to IDLE on the stop sample itself lets a
            // back-to-back start edge be caught without loss.
            S_STOP: begin
                if (clk_cnt == CNT_BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        pd_next    = shift_reg;
                        dv_next    = 1'b1;
                        pe_next    = PARITY_EN && ((^shift_reg ^ parity_bit) != PARITY_ODD);
                        state_next = S_IDLE;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    cnt_next = clk_cnt + 1'b1;
                end
            end

            // A line held low after a bad stop bit is not a new start bit.
            S_BREAK: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
// Bench for uart_rx_deserializer. Two instances share clk/rst: inst 0 without
// parity, inst 1 with even parity. Frame senders push expected events
// (cycle, byte, flags) computed from frame timing; one compare process checks
// all result outputs of both instances on every negedge.
module tb_uart_rx_deserializer;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] pd0, pd1;
    logic       dv0, dv1, pe0, pe1, fe0, fe1, busy0, busy1;

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (1'b0),
        .PARITY_ODD  (1'b0)
    ) dut0 (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx0),
        .p_data       (pd0),
        .data_valid   (dv0),
        .parity_error (pe0),
        .framing_error(fe0),
        .busy         (busy0)
    );

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (1'b1),
        .PARITY_ODD  (1'b0)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx1),
        .p_data       (pd1),
        .data_valid   (dv1),
        .parity_error (pe1),
        .framing_error(fe1),
        .busy         (busy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         inst;
        int         at;
        logic [7:0] d;
        bit         v;
        bit         pe;
        bit         fe;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mpd[2];
    int         total = 0;
    int         bad = 0;
    int         pq0[$];
    int         pq1[$];
    int         nfe[2];
    logic       lastpe[2];

    initial begin
        mpd[0] = '0; mpd[1] = '0;
        nfe[0] = 0;  nfe[1] = 0;
        lastpe[0] = 1'b0; lastpe[1] = 1'b0;
    end

    // Compare process: expected outputs derive from the event list only.
    always @(negedge clk) begin : cmp
        logic [10:0] got, want;
        logic        dv_e, pe_e, fe_e;
        for (int k = 0; k < 2; k++) begin
            dv_e = 1'b0; pe_e = 1'b0; fe_e = 1'b0;
            if (rst) begin
                mpd[k] = '0;
            end else begin
                foreach (evq[i]) begin
                    if (evq[i].inst == k && evq[i].at == cyc) begin
                        dv_e = evq[i].v;
                        pe_e = evq[i].pe;
                        fe_e = evq[i].fe;
                        if (evq[i].v) mpd[k] = evq[i].d;
                    end
                end
            end
            got  = (k == 0) ? {dv0, pe0, fe0, pd0} : {dv1, pe1, fe1, pd1};
            want = {dv_e, pe_e, fe_e, mpd[k]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL out inst=%0d cyc=%0d got dv=%b pe=%b fe=%b pd=%02h want dv=%b pe=%b fe=%b pd=%02h",
                         k, cyc, got[10], got[9], got[8], got[7:0],
                         want[10], want[9], want[8], want[7:0]);
            end
            if (got[10]) begin
                if (k == 0) pq0.push_back(cyc); else pq1.push_back(cyc);
                lastpe[k] = got[9];
            end
            if (got[8]) nfe[k]++;
        end
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].at <= cyc) evq.delete(i);
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", nm, got, got, want, want);
        end
    endtask

    // All driving happens 1 time unit after a rising edge.
    task automatic tick(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int k, input logic v);
        if (k == 0) rx0 = v; else rx1 = v;
    endtask

    // Drive one frame. Line falls after edge n; the receiver sees it at edge
    // n+3 (two synchroniser flops), samples the stop bit HALF + (9|10)*CPB later.
    task automatic send_frame(input int k, input logic [7:0] d, input bit par_en,
                              input bit pbit, input bit stop);
        ev_t e;
        int  n;
        n      = cyc;
        e.inst = k;
        e.at   = n + 3 + HALF + (par_en ? 10 : 9) * CPB;
        e.d    = d;
        e.v    = stop;
        e.pe   = stop && par_en && (((^d) ^ pbit) != 1'b0);
        e.fe   = !stop;
        evq.push_back(e);
        set_rx(k, 1'b0);
        tick(CPB);
        for (int b = 0; b < 8; b++) begin
            set_rx(k, d[b]);
            tick(CPB);
        end
        if (par_en) begin
            set_rx(k, pbit);
            tick(CPB);
        end
        set_rx(k, stop);
        tick(CPB);
    endtask

    initial begin : stim
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pd0", pd0, 0);
        chk("rst_flags0", {dv0, pe0, fe0, busy0}, 0);
        chk("rst_flags1", {dv1, pe1, fe1, busy1}, 0);
        rst = 1'b0;
        tick(5);

        // Single frame, latency from line fall to valid pulse.
        n = cyc;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk("a5_latency", (pq0.size() >= 1) ? pq0[0] - n : -1, 79);
        chk("a5_data", pd0, 8'hA5);
        chk("a5_busy_idle", busy0, 0);

        // Two-cycle low glitch.
        n = cyc;
        rx0 = 1'b0;
        tick(2);
        rx0 = 1'b1;
        tick(2);
        chk("glitch_busy_start", busy0, 1);
        tick(4);
        chk("glitch_busy_end", busy0, 0);
        chk("glitch_no_pulse", pq0.size(), 1);

        // Back-to-back frames.
        n = cyc;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk("b2b_count", pq0.size(), 3);
        chk("b2b_first", (pq0.size() >= 2) ? pq0[1] - n : -1, 79);
        chk("b2b_gap", (pq0.size() >= 3) ? pq0[2] - pq0[1] : -1, 80);
        chk("b2b_data", pd0, 8'h81);

        // Framing error followed by a held-low line.
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        tick(30);
        chk("break_busy", busy0, 1);
        chk("break_fe_count", nfe[0], 1);
        chk("break_pd_kept", pd0, 8'h81);
        rx0 = 1'b1;
        tick(6);
        chk("break_released", busy0, 0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk("after_break_data", pd0, 8'h12);
        chk("after_break_count", pq0.size(), 4);

        // Even parity on instance 1: 0x07 has three ones.
        n = cyc;
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        tick(4);
        chk("par_ok_latency", (pq1.size() >= 1) ? pq1[0] - n : -1, 87);
        chk("par_ok_pe", lastpe[1], 0);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        tick(4);
        chk("par_bad_pe", lastpe[1], 1);
        chk("par_bad_data", pd1, 8'h07);
        chk("par_count", pq1.size(), 2);

        // Reset during data bit 4 of a frame.
        rx0 = 1'b0;
        tick(CPB);
        for (int b = 0; b < 4; b++) begin
            rx0 = b[0];
            tick(CPB);
        end
        rx0 = 1'b1;
        tick(3);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_pd0", pd0, 0);
        chk("midrst_busy0", busy0, 0);
        chk("midrst_pd1", pd1, 0);
        @(posedge clk);
        #1;
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("midrst_no_pulse", pq0.size(), 4);
        send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk("post_rst_data", pd0, 8'hF0);
        chk("post_rst_count", pq0.size(), 5);

        tick(10);
        chk("events_drained", evq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
